// File: rtl/seg595_pkg.sv
// Frame layout shared by both ends of the 74HC595 display link.
// The first bit shifted in is the segment MSB. It ends in the top of the shift register.
package seg595_pkg;
    localparam int SEG_W      = 8;
    localparam int SEL_W      = 6;
    localparam int FRAME_BITS = SEG_W + SEL_W;
endpackage

// File: rtl/hc595_rx_sync.sv
// Purpose: multi-flop synchroniser for one link line, with a programmable reset level and a registered rise detect.
// Latency: dout is valid STAGES edges after the pin changes; rise pulses one edge after dout rises.
// Backpressure: none, free-running.
module hc595_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    assign dout = chain[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/hc595_rx.sv
// Purpose: 74HC595 link receiver. It rebuilds the seg/sel word from the stcp/shcp/ds/oe lines and flags frames with a wrong bit count.
// Latency: stcp pin to seg/sel/frame_valid takes SYNC_STAGES+2 edges; oe to disp_en takes SYNC_STAGES edges.
// Backpressure: none. Optional frame/error counters are built under HC595_RX_STATS_EN.
module hc595_rx
    import seg595_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SEG_W       = seg595_pkg::SEG_W,
    parameter int SEL_W       = seg595_pkg::SEL_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             ds,
    input  logic             oe,
    output logic [SEG_W-1:0] seg,
    output logic [SEL_W-1:0] sel,
    output logic             disp_en,
    output logic             frame_valid,
`ifdef HC595_RX_STATS_EN
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic             bit_err
);

    localparam int FRAME_BITS = SEG_W + SEL_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic shcp_sync, shcp_rise;
    logic stcp_sync, stcp_rise;
    logic ds_sync, ds_rise_unused;
    logic oe_sync, oe_rise_unused;
    logic ds_q;
    logic [FRAME_BITS-1:0] sr;
    logic [CNT_W-1:0]      cnt;

    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_shcp (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(shcp), .dout(shcp_sync), .rise(shcp_rise));
    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stcp (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(stcp), .dout(stcp_sync), .rise(stcp_rise));
    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ds (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(ds), .dout(ds_sync), .rise(ds_rise_unused));
    hc595_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_oe (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(oe), .dout(oe_sync), .rise(oe_rise_unused));

    assign disp_en = ~oe_sync;

    // Data is delayed by one flop so that it lines up with the registered shcp rise.
    // The shift then uses the ds value sampled together with the clock edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ds_q        <= 1'b0;
            sr          <= '0;
            cnt         <= '0;
            seg         <= '0;
            sel         <= '0;
            frame_valid <= 1'b0;
            bit_err     <= 1'b0;
`ifdef HC595_RX_STATS_EN
            frame_cnt   <= '0;
            err_cnt     <= '0;
`endif
        end else begin
            ds_q        <= ds_sync;
            frame_valid <= 1'b0;
            bit_err     <= 1'b0;
            if (shcp_rise) begin
                sr <= {sr[FRAME_BITS-2:0], ds_q};
            end
            if (stcp_rise) begin
                seg         <= sr[FRAME_BITS-1:SEL_W];
                sel         <= sr[SEL_W-1:0];
                frame_valid <= 1'b1;
                bit_err     <= (cnt != CNT_FULL);
`ifdef HC595_RX_STATS_EN
                frame_cnt   <= frame_cnt + 16'd1;
                if (cnt != CNT_FULL) begin
                    err_cnt <= err_cnt + 16'd1;
                end
`endif
                // A coincident shift belongs to the next frame.
                cnt <= shcp_rise ? CNT_W'(1) : '0;
            end else if (shcp_rise && cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    logic shcp_sync_unused, stcp_sync_unused;
    assign shcp_sync_unused = shcp_sync;
    assign stcp_sync_unused = stcp_sync;

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx. Stimulus is driven on falling edges, and outputs are sampled on falling edges.
// Frame expectations are hand-computed constants.
module tb_hc595_rx;

    localparam int S = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       shcp, stcp, ds, oe;
    logic [7:0] seg;
    logic [5:0] sel;
    logic       disp_en, frame_valid, bit_err;
`ifdef HC595_RX_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat;
    logic [7:0] got_seg;
    logic [5:0] got_sel;
    logic       got_err, got_fv2;

    always #5 sys_clk = ~sys_clk;

    hc595_rx #(.SYNC_STAGES(S)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
        .seg(seg), .sel(sel), .disp_en(disp_en), .frame_valid(frame_valid),
`ifdef HC595_RX_STATS_EN
        .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
        .bit_err(bit_err));

    task automatic shift_bit(input logic b);
        ds = b;
        repeat (2) @(negedge sys_clk);
        shcp = 1'b1;
        repeat (2) @(negedge sys_clk);
        shcp = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    // Raise stcp, optionally with shcp, and capture the first frame_valid within a bounded window.
    task automatic do_latch(input logic coincident);
        stcp = 1'b1;
        if (coincident) shcp = 1'b1;
        lat = 0;
        got_seg = 'x; got_sel = 'x; got_err = 1'bx; got_fv2 = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sys_clk);
            if (frame_valid === 1'b1) begin
                lat = i; got_seg = seg; got_sel = sel; got_err = bit_err;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge sys_clk);
            got_fv2 = frame_valid;
        end
        stcp = 1'b0;
        shcp = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shcp = i[0]; stcp = i[0]; ds = ~i[0]; oe = i[0];
            @(negedge sys_clk);
            n_checks++;
            if (seg !== 8'h00 || sel !== 6'h00 || disp_en !== 1'b0 || frame_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: seg=%h sel=%h disp_en=%b fv=%b, want 00 00 0 0", seg, sel, disp_en, frame_valid);
            end
        end
        shcp = 1'b0; stcp = 1'b0; ds = 1'b0; oe = 1'b1;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            n_checks++;
            if (frame_valid !== 1'b0 || disp_en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release: fv=%b disp_en=%b, want 0 0", frame_valid, disp_en);
            end
        end
    endtask

    task automatic test_good_frame;
        shift_bits({2'b00, 8'hC0, 6'b111110}, 14);
        do_latch(1'b0);
        n_checks++;
        if (lat !== S + 2) begin n_fail++; $display("FAIL good_latency: got %0d want %0d", lat, S + 2); end
        n_checks++;
        if (got_seg !== 8'hC0 || got_sel !== 6'h3E) begin
            n_fail++; $display("FAIL good_data: seg=%h sel=%h want c0 3e", got_seg, got_sel);
        end
        n_checks++;
        if (got_err !== 1'b0 || got_fv2 !== 1'b0) begin
            n_fail++; $display("FAIL good_err_pulse: err=%b fv_next=%b want 0 0", got_err, got_fv2);
        end
    endtask

    task automatic test_short_frame;
        shift_bits(16'h15A5, 13);
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'h56 || got_sel !== 6'h25 || got_err !== 1'b1) begin
            n_fail++; $display("FAIL short_frame: seg=%h sel=%h err=%b want 56 25 1", got_seg, got_sel, got_err);
        end
        shift_bits({2'b00, 8'h3C, 6'h15}, 14);
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'h3C || got_sel !== 6'h15 || got_err !== 1'b0) begin
            n_fail++; $display("FAIL after_short: seg=%h sel=%h err=%b want 3c 15 0", got_seg, got_sel, got_err);
        end
    endtask

    task automatic test_coincident;
        shift_bits(16'h00F0, 13);
        ds = 1'b1;
        repeat (2) @(negedge sys_clk);
        do_latch(1'b1);
        n_checks++;
        if (got_seg !== 8'h83 || got_sel !== 6'h30 || got_err !== 1'b1) begin
            n_fail++; $display("FAIL coincident_latch: seg=%h sel=%h err=%b want 83 30 1", got_seg, got_sel, got_err);
        end
        n_checks++;
        if (lat !== S + 2) begin n_fail++; $display("FAIL coincident_latency: got %0d want %0d", lat, S + 2); end
        shift_bits(16'h096C, 13);
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'hA5 || got_sel !== 6'h2C || got_err !== 1'b0) begin
            n_fail++; $display("FAIL coincident_next: seg=%h sel=%h err=%b want a5 2c 0", got_seg, got_sel, got_err);
        end
    endtask

    task automatic test_zero_shift;
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'hA5 || got_sel !== 6'h2C || got_err !== 1'b1) begin
            n_fail++; $display("FAIL zero_shift: seg=%h sel=%h err=%b want a5 2c 1", got_seg, got_sel, got_err);
        end
    endtask

    task automatic test_overflow;
        shift_bits({1'b0, 1'b0, 8'h81, 6'h01}, 15);
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'h81 || got_sel !== 6'h01 || got_err !== 1'b1) begin
            n_fail++; $display("FAIL overflow: seg=%h sel=%h err=%b want 81 01 1", got_seg, got_sel, got_err);
        end
    endtask

    task automatic test_mid_reset;
        shift_bits(16'h001F, 5);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (seg !== 8'h00 || sel !== 6'h00) begin
            n_fail++; $display("FAIL mid_reset_clear: seg=%h sel=%h want 00 00", seg, sel);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        shift_bits({2'b00, 8'h12, 6'h34}, 14);
        do_latch(1'b0);
        n_checks++;
        if (got_seg !== 8'h12 || got_sel !== 6'h34 || got_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_frame: seg=%h sel=%h err=%b want 12 34 0", got_seg, got_sel, got_err);
        end
    endtask

    task automatic test_oe;
        int t;
        oe = 1'b0;
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (disp_en === 1'b1) begin t = i; break; end
        end
        n_checks++;
        if (t !== S) begin n_fail++; $display("FAIL oe_enable_latency: got %0d want %0d", t, S); end
        repeat (2) @(negedge sys_clk);
        oe = 1'b1;
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (disp_en === 1'b0) begin t = i; break; end
        end
        n_checks++;
        if (t !== S) begin n_fail++; $display("FAIL oe_disable_latency: got %0d want %0d", t, S); end
        n_checks++;
        if (seg !== 8'h12 || sel !== 6'h34 || frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL oe_no_effect: seg=%h sel=%h fv=%b want 12 34 0", seg, sel, frame_valid);
        end
    endtask

`ifdef HC595_RX_STATS_EN
    task automatic test_stats;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        for (int f = 0; f < 7; f++) begin
            if (f == 2 || f == 5) shift_bits(16'h0AAA, 13);
            else shift_bits(16'h1234, 14);
            do_latch(1'b0);
        end
        n_checks++;
        if (frame_cnt !== 16'd7 || err_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stats_count: frame_cnt=%0d err_cnt=%0d want 7 2", frame_cnt, err_cnt);
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_reset: frame_cnt=%0d err_cnt=%0d want 0 0", frame_cnt, err_cnt);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask
`endif

    initial begin
        shcp = 1'b0; stcp = 1'b0; ds = 1'b0; oe = 1'b1; sys_rst_n = 1'b0;
        test_reset();
        test_good_frame();
        test_short_frame();
        test_coincident();
        test_zero_shift();
        test_overflow();
        test_mid_reset();
        test_oe();
`ifdef HC595_RX_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
